// File: rtl/ofs_fim_eth_if_pkg.sv
// ofs_fim_eth_if_pkg: shared Ethernet interface widths, RX buffer beat layout and drop-FSM states.
package ofs_fim_eth_if_pkg;

    localparam int ETH_PACKET_WIDTH   = 64;
    localparam int ETH_RX_ERROR_WIDTH = 6;

    typedef struct packed {
        logic [ETH_PACKET_WIDTH-1:0]   tdata;
        logic [ETH_PACKET_WIDTH/8-1:0] tkeep;
        logic                          tlast;
    } eth_rx_buf_beat_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_WR,
        RX_DROP
    } eth_rx_drop_state_e;

endpackage

// File: rtl/eth_rx_pkt_ram.sv
// eth_rx_pkt_ram: simple dual-port beat RAM with a registered, write-first read port.
module eth_rx_pkt_ram #(
    parameter int AW = 9,
    parameter int W  = 73
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [2**AW];

    // Write-first so a beat written this edge is visible to the reader next cycle
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
    end

endmodule

// File: rtl/eth_rx_err_pkt_drop.sv
// eth_rx_err_pkt_drop: store-and-forward RX packet buffer that forwards only clean packets
// and drops errored or overflowing ones by rolling back the write pointer.
module eth_rx_err_pkt_drop
    import ofs_fim_eth_if_pkg::*;
#(
    parameter int DATA_W     = ETH_PACKET_WIDTH,
    parameter int ERR_W      = ETH_RX_ERROR_WIDTH,
    parameter int DEPTH_LOG2 = 9,
    parameter int CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_tvalid,
    output logic                s_tready,
    input  logic [DATA_W-1:0]   s_tdata,
    input  logic [DATA_W/8-1:0] s_tkeep,
    input  logic                s_tlast,
    input  logic [ERR_W-1:0]    s_tuser,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [DATA_W-1:0]   m_tdata,
    output logic [DATA_W/8-1:0] m_tkeep,
    output logic                m_tlast,
    output logic [CNT_W-1:0]    pkt_fwd_cnt,
    output logic [CNT_W-1:0]    pkt_err_cnt,
    output logic [CNT_W-1:0]    pkt_ovf_cnt
);

    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    eth_rx_drop_state_e state;
    logic [PW-1:0]      wr_ptr, commit_ptr, rd_ptr, rd_ptr_nxt;
    logic [ERR_W-1:0]   err_flag;
    logic               full, avail, accept, wr_en, bad, load;
    eth_rx_buf_beat_t   wr_beat, rd_beat;

    assign full       = (wr_ptr - rd_ptr) == DEPTH;
    assign avail      = rd_ptr != commit_ptr;
    assign accept     = s_tvalid & s_tready;
    assign wr_en      = accept & (state != RX_DROP) & ~full;
    assign bad        = |(err_flag | s_tuser);
    assign load       = avail & (~m_tvalid | m_tready);
    assign rd_ptr_nxt = load ? rd_ptr + PW'(1) : rd_ptr;
    assign wr_beat    = '{tdata: s_tdata, tkeep: s_tkeep, tlast: s_tlast};

    // Read address runs one step ahead so the RAM output already holds RAM[rd_ptr]
    eth_rx_pkt_ram #(
        .AW (DEPTH_LOG2),
        .W  ($bits(eth_rx_buf_beat_t))
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr[DEPTH_LOG2-1:0]),
        .wdata (wr_beat),
        .raddr (rd_ptr_nxt[DEPTH_LOG2-1:0]),
        .rdata (rd_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RX_IDLE;
            s_tready    <= 1'b0;
            wr_ptr      <= '0;
            commit_ptr  <= '0;
            err_flag    <= '0;
            pkt_fwd_cnt <= '0;
            pkt_err_cnt <= '0;
            pkt_ovf_cnt <= '0;
        end else begin
            s_tready <= 1'b1;
            if (accept) begin
                if (state == RX_DROP) begin
                    if (s_tlast) begin
                        pkt_ovf_cnt <= pkt_ovf_cnt + CNT_W'(1);
                        state       <= RX_IDLE;
                    end
                end else if (full) begin
                    wr_ptr   <= commit_ptr;
                    err_flag <= '0;
                    if (s_tlast) pkt_ovf_cnt <= pkt_ovf_cnt + CNT_W'(1);
                    state <= s_tlast ? RX_IDLE : RX_DROP;
                end else if (s_tlast) begin
                    if (bad) begin
                        wr_ptr      <= commit_ptr;
                        pkt_err_cnt <= pkt_err_cnt + CNT_W'(1);
                    end else begin
                        wr_ptr      <= wr_ptr + PW'(1);
                        commit_ptr  <= wr_ptr + PW'(1);
                        pkt_fwd_cnt <= pkt_fwd_cnt + CNT_W'(1);
                    end
                    err_flag <= '0;
                    state    <= RX_IDLE;
                end else begin
                    wr_ptr   <= wr_ptr + PW'(1);
                    err_flag <= err_flag | s_tuser;
                    state    <= RX_WR;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr   <= '0;
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
        end else if (load) begin
            rd_ptr   <= rd_ptr_nxt;
            m_tvalid <= 1'b1;
            m_tdata  <= rd_beat.tdata;
            m_tkeep  <= rd_beat.tkeep;
            m_tlast  <= rd_beat.tlast;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_eth_rx_err_pkt_drop.sv
// tb_eth_rx_err_pkt_drop: directed cycle table plus multi-cycle sequences for the RX drop buffer.
module tb_eth_rx_err_pkt_drop;

    typedef logic [72:0] beat_t;

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        logic [5:0]  u;
        logic        ev;
        logic [63:0] ed;
        logic [7:0]  ek;
        logic        el;
        logic [31:0] fwd;
        logic [31:0] err;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_tvalid, s_tready, s_tlast;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic [5:0]  s_tuser;
    logic        m_tvalid, m_tready, m_tlast;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic [31:0] pkt_fwd_cnt, pkt_err_cnt, pkt_ovf_cnt;

    int    total = 0;
    int    bad = 0;
    beat_t got[$];
    beat_t exp[$];
    logic  chk_stable = 1'b0;
    logic  prev_stall = 1'b0;
    beat_t prev_beat = '0;
    row_t  tbl[15];
    logic [63:0] bp_d[8];
    logic [7:0]  bp_k[8];

    always #5 clk = ~clk;

    eth_rx_err_pkt_drop #(
        .DATA_W     (64),
        .ERR_W      (6),
        .DEPTH_LOG2 (4),
        .CNT_W      (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tlast     (s_tlast),
        .s_tuser     (s_tuser),
        .m_tvalid    (m_tvalid),
        .m_tready    (m_tready),
        .m_tdata     (m_tdata),
        .m_tkeep     (m_tkeep),
        .m_tlast     (m_tlast),
        .pkt_fwd_cnt (pkt_fwd_cnt),
        .pkt_err_cnt (pkt_err_cnt),
        .pkt_ovf_cnt (pkt_ovf_cnt)
    );

    task automatic chk(string name, logic [127:0] act, logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", name, act, want);
        end
    endtask

    function automatic row_t mk(logic v, logic [63:0] d, logic [7:0] k, logic l, logic [5:0] u,
                                logic ev, logic [63:0] ed, logic [7:0] ek, logic el,
                                logic [31:0] f, logic [31:0] e);
        row_t r;
        r = '{v: v, d: d, k: k, l: l, u: u, ev: ev, ed: ed, ek: ek, el: el, fwd: f, err: e};
        return r;
    endfunction

    // Advance one cycle from posedge+1 to posedge+1, sampling outputs on the negedge between
    task automatic tick();
        beat_t cur;
        @(negedge clk);
        cur = {m_tdata, m_tkeep, m_tlast};
        if (chk_stable && prev_stall) begin
            chk("stall_valid", 128'(m_tvalid), 128'(1));
            chk("stall_beat", 128'(cur), 128'(prev_beat));
        end
        if (m_tvalid && m_tready) got.push_back(cur);
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = cur;
        @(posedge clk);
        #1;
    endtask

    task automatic send(logic [63:0] d, logic [7:0] k, logic l, logic [5:0] u);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tkeep  = k;
        s_tlast  = l;
        s_tuser  = u;
        tick();
        s_tvalid = 1'b0;
    endtask

    task automatic drain(int n);
        for (int c = 0; c < 2000 && got.size() < n; c++) tick();
        repeat (3) tick();
    endtask

    task automatic chk_stream(string name);
        chk({name, "_len"}, 128'(got.size()), 128'(exp.size()));
        for (int i = 0; i < got.size() && i < exp.size(); i++)
            chk({name, "_beat"}, 128'(got[i]), 128'(exp[i]));
    endtask

    initial begin
        tbl[0]  = mk(1'b1, 64'hA000_0000_0000_0000, 8'hFF, 1'b0, 6'h00, 1'b0, 64'h0, 8'h00, 1'b0, 32'd0, 32'd0);
        tbl[1]  = mk(1'b1, 64'hA000_0000_0000_0001, 8'hFF, 1'b0, 6'h00, 1'b0, 64'h0, 8'h00, 1'b0, 32'd0, 32'd0);
        tbl[2]  = mk(1'b1, 64'hA000_0000_0000_0002, 8'hFF, 1'b0, 6'h00, 1'b0, 64'h0, 8'h00, 1'b0, 32'd0, 32'd0);
        tbl[3]  = mk(1'b1, 64'hA000_0000_0000_0003, 8'h3F, 1'b1, 6'h00, 1'b0, 64'h0, 8'h00, 1'b0, 32'd0, 32'd0);
        tbl[4]  = mk(1'b0, 64'h0, 8'h00, 1'b0, 6'h00, 1'b0, 64'h0, 8'h00, 1'b0, 32'd1, 32'd0);
        tbl[5]  = mk(1'b0, 64'h0, 8'h00, 1'b0, 6'h00, 1'b1, 64'hA000_0000_0000_0000, 8'hFF, 1'b0, 32'd1, 32'd0);
        tbl[6]  = mk(1'b1, 64'hB000_0000_0000_0000, 8'hFF, 1'b0, 6'h00, 1'b1, 64'hA000_0000_0000_0001, 8'hFF, 1'b0, 32'd1, 32'd0);
        tbl[7]  = mk(1'b1, 64'hB000_0000_0000_0001, 8'hFF, 1'b0, 6'h01, 1'b1, 64'hA000_0000_0000_0002, 8'hFF, 1'b0, 32'd1, 32'd0);
        tbl[8]  = mk(1'b1, 64'hB000_0000_0000_0002, 8'hFF, 1'b1, 6'h00, 1'b1, 64'hA000_0000_0000_0003, 8'h3F, 1'b1, 32'd1, 32'd0);
        tbl[9]  = mk(1'b1, 64'hC000_0000_0000_0000, 8'hFF, 1'b0, 6'h00, 1'b0, 64'h0, 8'h00, 1'b0, 32'd1, 32'd1);
        tbl[10] = mk(1'b1, 64'hC000_0000_0000_0001, 8'h01, 1'b1, 6'h00, 1'b0, 64'h0, 8'h00, 1'b0, 32'd1, 32'd1);
        tbl[11] = mk(1'b0, 64'h0, 8'h00, 1'b0, 6'h00, 1'b0, 64'h0, 8'h00, 1'b0, 32'd2, 32'd1);
        tbl[12] = mk(1'b0, 64'h0, 8'h00, 1'b0, 6'h00, 1'b1, 64'hC000_0000_0000_0000, 8'hFF, 1'b0, 32'd2, 32'd1);
        tbl[13] = mk(1'b0, 64'h0, 8'h00, 1'b0, 6'h00, 1'b1, 64'hC000_0000_0000_0001, 8'h01, 1'b1, 32'd2, 32'd1);
        tbl[14] = mk(1'b0, 64'h0, 8'h00, 1'b0, 6'h00, 1'b0, 64'h0, 8'h00, 1'b0, 32'd2, 32'd1);

        rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tuser = '0;
        m_tready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("rst_s_tready", 128'(s_tready), 128'(0));
        chk("rst_counters", 128'({pkt_fwd_cnt, pkt_err_cnt, pkt_ovf_cnt}), 128'(0));
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("s_tready_up", 128'(s_tready), 128'(1));

        // Good 4-beat packet then errored 3-beat packet and a good 2-beat packet, cycle-exact
        for (int i = 0; i < 15; i++) begin
            s_tvalid = tbl[i].v; s_tdata = tbl[i].d; s_tkeep = tbl[i].k;
            s_tlast = tbl[i].l; s_tuser = tbl[i].u;
            @(negedge clk);
            chk($sformatf("row%0d_valid", i), 128'(m_tvalid), 128'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("row%0d_beat", i), 128'({m_tdata, m_tkeep, m_tlast}),
                               128'({tbl[i].ed, tbl[i].ek, tbl[i].el}));
            chk($sformatf("row%0d_fwd", i), 128'(pkt_fwd_cnt), 128'(tbl[i].fwd));
            chk($sformatf("row%0d_err", i), 128'(pkt_err_cnt), 128'(tbl[i].err));
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0;

        // Overflow: first 10-beat packet held, second does not fit in 16 entries
        got.delete(); exp.delete();
        m_tready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            send(64'h3000 + 64'(k), 8'hFF, k == 9, 6'h00);
            exp.push_back({64'h3000 + 64'(k), 8'hFF, k == 9});
        end
        for (int k = 0; k < 10; k++) send(64'h4000 + 64'(k), 8'hFF, k == 9, 6'h00);
        repeat (4) tick();
        chk("ovf_cnt", 128'(pkt_ovf_cnt), 128'(1));
        chk("ovf_fwd", 128'(pkt_fwd_cnt), 128'(3));
        chk("ovf_err", 128'(pkt_err_cnt), 128'(1));
        chk("ovf_held", 128'({m_tvalid, m_tdata}), 128'({1'b1, 64'h3000}));
        m_tready = 1'b1;
        drain(10);
        chk_stream("ovf");

        // Backpressure with random m_tready
        got.delete(); exp.delete();
        for (int k = 0; k < 8; k++) begin
            bp_d[k] = {$urandom, $urandom};
            bp_k[k] = 8'($urandom_range(1, 255));
            exp.push_back({bp_d[k], bp_k[k], k == 7});
        end
        chk_stable = 1'b1;
        prev_stall = 1'b0;
        for (int c = 0; c < 400 && got.size() < 8; c++) begin
            m_tready = 1'($urandom_range(0, 1));
            s_tvalid = c < 8;
            if (c < 8) begin
                s_tdata = bp_d[c]; s_tkeep = bp_k[c]; s_tlast = c == 7; s_tuser = '0;
            end
            tick();
        end
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) tick();
        chk_stable = 1'b0;
        chk_stream("bp");
        chk("bp_fwd", 128'(pkt_fwd_cnt), 128'(4));

        // Reset mid-packet while a beat is held on the output
        got.delete(); exp.delete();
        m_tready = 1'b0;
        send(64'h5555, 8'h01, 1'b1, 6'h00);
        repeat (3) tick();
        chk("pre_rst_valid", 128'(m_tvalid), 128'(1));
        chk("pre_rst_fwd", 128'(pkt_fwd_cnt), 128'(5));
        send(64'h5A00, 8'hFF, 1'b0, 6'h00);
        send(64'h5A01, 8'hFF, 1'b0, 6'h00);
        rst_n = 1'b0;
        #1;
        chk("async_m_tvalid", 128'(m_tvalid), 128'(0));
        chk("async_out", 128'({m_tdata, m_tkeep, m_tlast}), 128'(0));
        chk("async_s_tready", 128'(s_tready), 128'(0));
        chk("async_counters", 128'({pkt_fwd_cnt, pkt_err_cnt, pkt_ovf_cnt}), 128'(0));
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        chk("post_rst_s_tready", 128'(s_tready), 128'(1));
        m_tready = 1'b1;
        got.delete();
        for (int k = 0; k < 4; k++) begin
            send(64'h7000 + 64'(k), 8'hF0 | 8'(k), k == 3, 6'h00);
            exp.push_back({64'h7000 + 64'(k), 8'hF0 | 8'(k), k == 3});
        end
        drain(4);
        chk_stream("rst");
        chk("rst_counts", 128'({pkt_fwd_cnt, pkt_err_cnt, pkt_ovf_cnt}), 128'({32'd1, 32'd0, 32'd0}));

        // Pointer wrap: 300 back-to-back 3-beat packets
        got.delete(); exp.delete();
        for (int p = 0; p < 300; p++)
            for (int b = 0; b < 3; b++) begin
                send({16'h6000, 16'(p), 16'h0, 16'(b)}, 8'hFF, b == 2, 6'h00);
                exp.push_back({16'h6000, 16'(p), 16'h0, 16'(b), 8'hFF, b == 2});
            end
        drain(900);
        chk_stream("wrap");
        chk("wrap_counts", 128'({pkt_fwd_cnt, pkt_err_cnt, pkt_ovf_cnt}), 128'({32'd301, 32'd0, 32'd0}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
